// File: rtl/dual_port_bram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port block RAM.
//   clear_state_t : clear sequencer states
//   addr_width()  : address bits for a given depth (never less than 1)
//   num_bytes()   : byte lanes per word
package dual_port_bram_pkg;

    typedef enum logic [0:0] {
        CLR_IDLE,
        CLR_RUN
    } clear_state_t;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned num_bytes(input int unsigned dw, input int unsigned bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/dual_port_bram_be_if.sv
// Port A (write), port B (read) and clear/busy signals of dual_port_bram_be.
//   master : drives requests (i_*), observes o_dob / o_dob_valid / o_busy
//   slave  : the RAM itself
interface dual_port_bram_be_if
    import dual_port_bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned BYTE_WIDTH = 8
);
    localparam int unsigned ADDRESS_WIDTH = addr_width(DATA_DEPTH);
    localparam int unsigned NUM_BYTES     = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic                     i_ena;
    logic [NUM_BYTES-1:0]     i_wea;
    logic [ADDRESS_WIDTH-1:0] i_addra;
    logic [DATA_WIDTH-1:0]    i_dia;
    logic                     i_enb;
    logic [ADDRESS_WIDTH-1:0] i_addrb;
    logic [DATA_WIDTH-1:0]    o_dob;
    logic                     o_dob_valid;
    logic                     i_clear;
    logic                     o_busy;

    modport master (
        output i_ena, i_wea, i_addra, i_dia, i_enb, i_addrb, i_clear,
        input  o_dob, o_dob_valid, o_busy
    );

    modport slave (
        input  i_ena, i_wea, i_addra, i_dia, i_enb, i_addrb, i_clear,
        output o_dob, o_dob_valid, o_busy
    );

endinterface

// File: rtl/dual_port_bram_be_clear_sequencer.sv
// Clear sequencer: walks addresses 0..DATA_DEPTH-1, one per cycle, and takes
// over the RAM write port while doing so.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : start request (ignored while running)
//   o_busy       : sequence in progress
//   o_clr_we     : write CLEAR_VALUE this cycle
//   o_clr_addr   : address being cleared
module bram_clear_sequencer
    import dual_port_bram_pkg::*;
#(
    parameter int unsigned DATA_DEPTH     = 1024,
    parameter int unsigned ADDRESS_WIDTH  = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clear,
    output logic                     o_busy,
    output logic                     o_clr_we,
    output logic [ADDRESS_WIDTH-1:0] o_clr_addr
);

    clear_state_t             state, state_nx;
    logic [ADDRESS_WIDTH-1:0] cnt, cnt_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CLR_IDLE: begin
                if (i_clear) begin
                    state_nx = CLR_RUN;
                    cnt_nx   = '0;
                end
            end
            CLR_RUN: begin
                // Stop on the last real word so a non-power-of-two depth never overruns.
                if (32'(cnt) == DATA_DEPTH - 1) begin
                    state_nx = CLR_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ADDRESS_WIDTH'(1);
                end
            end
            default: state_nx = CLR_IDLE;
        endcase
    end

    assign o_busy     = (state == CLR_RUN);
    assign o_clr_we   = (state == CLR_RUN);
    assign o_clr_addr = cnt;

endmodule

// File: rtl/dual_port_bram_be.sv
// Simple dual-port RAM with per-byte write enables, 1- or 2-cycle read
// latency with a valid strobe, selectable collision behaviour and a
// built-in clear sequencer.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : port A write, port B read, clear request / busy
module dual_port_bram_be
    import dual_port_bram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 16,
    parameter int unsigned           DATA_DEPTH     = 1024,
    parameter int unsigned           BYTE_WIDTH     = 8,
    parameter int unsigned           READ_LATENCY   = 1,
    parameter bit                    WRITE_FIRST    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dual_port_bram_be_if.slave   bus
);

    localparam int unsigned ADDRESS_WIDTH = addr_width(DATA_DEPTH);
    localparam int unsigned NUM_BYTES     = num_bytes(DATA_WIDTH, BYTE_WIDTH);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0]    mem [DATA_DEPTH];
    logic                     busy, clr_we;
    logic [ADDRESS_WIDTH-1:0] clr_addr;
    logic                     wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0]    rd_old, rd_word;
    logic [DATA_WIDTH-1:0]    dob_q;
    logic                     dob_valid_q;

    bram_clear_sequencer #(
        .DATA_DEPTH     (DATA_DEPTH),
        .ADDRESS_WIDTH  (ADDRESS_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (bus.i_clear),
        .o_busy     (busy),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    // Writes are also held off during reset so reset never disturbs contents.
    assign wr_ok = bus.i_ena && !busy && !i_rst && (32'(bus.i_addra) < DATA_DEPTH);
    assign rd_ok = bus.i_enb && !busy;

    always_ff @(posedge i_clk) begin
        if (clr_we && !i_rst) begin
            mem[clr_addr] <= CLEAR_VALUE;
        end else if (wr_ok) begin
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                if (bus.i_wea[k]) begin
                    mem[bus.i_addra][k*BYTE_WIDTH +: BYTE_WIDTH] <= bus.i_dia[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Write-first collisions are resolved by a bypass merge, not by the RAM.
    always_comb begin
        rd_old = '0;
        if (32'(bus.i_addrb) < DATA_DEPTH) begin
            rd_old = mem[bus.i_addrb];
        end
        rd_word = rd_old;
        if (WRITE_FIRST && wr_ok && (bus.i_addra == bus.i_addrb)) begin
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                if (bus.i_wea[k]) begin
                    rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = bus.i_dia[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s_data;
        logic                  s_valid;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                s_data      <= '0;
                s_valid     <= 1'b0;
                dob_q       <= '0;
                dob_valid_q <= 1'b0;
            end else begin
                s_valid     <= rd_ok;
                dob_valid_q <= s_valid;
                if (rd_ok) s_data <= rd_word;
                if (s_valid) dob_q <= s_data;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                dob_q       <= '0;
                dob_valid_q <= 1'b0;
            end else begin
                dob_valid_q <= rd_ok;
                if (rd_ok) dob_q <= rd_word;
            end
        end
    end

    assign bus.o_dob       = dob_q;
    assign bus.o_dob_valid = dob_valid_q;
    assign bus.o_busy      = busy;

endmodule
